// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and constants for the dual-channel writeback arbiter.
// The writeback request type is sized for the default data width.
package reg_wb_arbiter_pkg;

  localparam int WB_FIFO_DEPTH_DEFAULT = 4;
  localparam int WB_WIDTH_DEFAULT      = 32;
  localparam int WB_NUM_FWD            = 4;

  typedef struct packed {
    logic [4:0]                  addr;
    logic [WB_WIDTH_DEFAULT-1:0] data;
  } wb_req_t;

  // Even registers live in bank 0 and odd registers in bank 1.
  function automatic logic bank_of(input logic [4:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Bundle of the writeback request, regfile write and forwarding signals.
// Slave is the arbiter side and master is the pipeline/regfile side.
interface reg_wb_arbiter_if #(
  parameter int WIDTH = 32
);

  logic             wb0_valid_i;
  logic [4:0]       wb0_addr_i;
  logic [WIDTH-1:0] wb0_data_i;
  logic             wb1_valid_i;
  logic [4:0]       wb1_addr_i;
  logic [WIDTH-1:0] wb1_data_i;
  logic             wb_ready_o;

  logic [4:0]       wa0_o;
  logic             we0_o;
  logic [WIDTH-1:0] wd0_o;
  logic [4:0]       wa1_o;
  logic             we1_o;
  logic [WIDTH-1:0] wd1_o;

  logic [4:0]       fra0_i;
  logic [4:0]       fra1_i;
  logic [4:0]       fra2_i;
  logic [4:0]       fra3_i;
  logic             fhit0_o;
  logic             fhit1_o;
  logic             fhit2_o;
  logic             fhit3_o;
  logic [WIDTH-1:0] fdata0_o;
  logic [WIDTH-1:0] fdata1_o;
  logic [WIDTH-1:0] fdata2_o;
  logic [WIDTH-1:0] fdata3_o;

  modport slave (
    input  wb0_valid_i, wb0_addr_i, wb0_data_i,
    input  wb1_valid_i, wb1_addr_i, wb1_data_i,
    output wb_ready_o,
    output wa0_o, we0_o, wd0_o, wa1_o, we1_o, wd1_o,
    input  fra0_i, fra1_i, fra2_i, fra3_i,
    output fhit0_o, fhit1_o, fhit2_o, fhit3_o,
    output fdata0_o, fdata1_o, fdata2_o, fdata3_o
  );

  modport master (
    output wb0_valid_i, wb0_addr_i, wb0_data_i,
    output wb1_valid_i, wb1_addr_i, wb1_data_i,
    input  wb_ready_o,
    input  wa0_o, we0_o, wd0_o, wa1_o, we1_o, wd1_o,
    output fra0_i, fra1_i, fra2_i, fra3_i,
    input  fhit0_o, fhit1_o, fhit2_o, fhit3_o,
    input  fdata0_o, fdata1_o, fdata2_o, fdata3_o
  );

endinterface

// File: rtl/reg_wb_arbiter_wb_bank_fifo.sv
// Per-bank pending-write queue: up to two pushes and one pop per cycle,
// plus a youngest-match lookup for each forwarding read address.
module wb_bank_fifo
  import reg_wb_arbiter_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH_DEFAULT,
  parameter int DEPTH = WB_FIFO_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push0,
  input  logic [4:0]       i_addr0,
  input  logic [WIDTH-1:0] i_data0,
  input  logic             i_push1,
  input  logic [4:0]       i_addr1,
  input  logic [WIDTH-1:0] i_data1,
  output logic [CNT_W-1:0] o_count,
  output logic             o_head_valid,
  output logic [4:0]       o_head_addr,
  output logic [WIDTH-1:0] o_head_data,
  input  logic [4:0]       i_fra   [WB_NUM_FWD],
  output logic             o_fhit  [WB_NUM_FWD],
  output logic [WIDTH-1:0] o_fdata [WB_NUM_FWD]
);

  localparam int PW1 = PTR_W + 1;

  logic [4:0]       r_addr [DEPTH];
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0] w_tail1;
  logic             w_pop;
  logic [PTR_W-1:0] w_slot [DEPTH];
  logic             w_live [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
    logic [PTR_W:0] s;
    s = {1'b0, p} + PW1'(k);
    if (s >= PW1'(DEPTH)) s = s - PW1'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  assign w_tail1 = ptr_inc(r_tail);
  assign w_pop   = (r_count != '0);

  // Channel 0 always takes the tail slot when present, so program order is kept.
  always_ff @(posedge clk) begin
    if (i_push0 | i_push1) begin
      r_addr[r_tail] <= i_push0 ? i_addr0 : i_addr1;
      r_data[r_tail] <= i_push0 ? i_data0 : i_data1;
    end
    if (i_push0 & i_push1) begin
      r_addr[w_tail1] <= i_addr1;
      r_data[w_tail1] <= i_data1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(i_push0) + CNT_W'(i_push1) - CNT_W'(w_pop);
      if (w_pop) r_head <= ptr_inc(r_head);
      if (i_push0 & i_push1)      r_tail <= ptr_inc(w_tail1);
      else if (i_push0 | i_push1) r_tail <= w_tail1;
    end
  end

  assign o_count      = r_count;
  assign o_head_valid = w_pop;
  assign o_head_addr  = r_addr[r_head];
  assign o_head_data  = r_data[r_head];

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_slot[k] = ptr_add(r_head, k);
      w_live[k] = (CNT_W'(k) < r_count);
    end
  end

  // Walk from head to tail so the youngest match is the one left standing.
  always_comb begin
    for (int n = 0; n < WB_NUM_FWD; n++) begin
      o_fhit[n]  = 1'b0;
      o_fdata[n] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        if (w_live[k] && (r_addr[w_slot[k]] == i_fra[n])) begin
          o_fhit[n]  = 1'b1;
          o_fdata[n] = r_data[w_slot[k]];
        end
      end
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Dual-channel writeback arbiter: splits writebacks into even/odd bank queues
// that drain one entry per cycle to the regfile, with read-address forwarding.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH_DEFAULT,
  parameter int DEPTH = WB_FIFO_DEPTH_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  reg_wb_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             w_ready;
  logic             w_acc0;
  logic             w_acc1;
  logic [CNT_W-1:0] w_count0;
  logic [CNT_W-1:0] w_count1;
  logic             w_headValid0;
  logic             w_headValid1;
  logic [4:0]       w_headAddr0;
  logic [4:0]       w_headAddr1;
  logic [WIDTH-1:0] w_headData0;
  logic [WIDTH-1:0] w_headData1;
  logic [4:0]       w_fra   [WB_NUM_FWD];
  logic             w_hit0  [WB_NUM_FWD];
  logic             w_hit1  [WB_NUM_FWD];
  logic [WIDTH-1:0] w_data0 [WB_NUM_FWD];
  logic [WIDTH-1:0] w_data1 [WB_NUM_FWD];
  logic             w_fhit  [WB_NUM_FWD];
  logic [WIDTH-1:0] w_fdata [WB_NUM_FWD];

  // Two free slots per bank guarantee room for a same-bank pair.
  assign w_ready = !rst && (w_count0 <= CNT_W'(DEPTH - 2)) && (w_count1 <= CNT_W'(DEPTH - 2));
  assign bus.wb_ready_o = w_ready;

  assign w_acc0 = bus.wb0_valid_i && w_ready && (bus.wb0_addr_i != 5'd0);
  assign w_acc1 = bus.wb1_valid_i && w_ready && (bus.wb1_addr_i != 5'd0);

  assign w_fra[0] = bus.fra0_i;
  assign w_fra[1] = bus.fra1_i;
  assign w_fra[2] = bus.fra2_i;
  assign w_fra[3] = bus.fra3_i;

  wb_bank_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank0 (
    .clk          (clk),
    .rst          (rst),
    .i_push0      (w_acc0 && !bank_of(bus.wb0_addr_i)),
    .i_addr0      (bus.wb0_addr_i),
    .i_data0      (bus.wb0_data_i),
    .i_push1      (w_acc1 && !bank_of(bus.wb1_addr_i)),
    .i_addr1      (bus.wb1_addr_i),
    .i_data1      (bus.wb1_data_i),
    .o_count      (w_count0),
    .o_head_valid (w_headValid0),
    .o_head_addr  (w_headAddr0),
    .o_head_data  (w_headData0),
    .i_fra        (w_fra),
    .o_fhit       (w_hit0),
    .o_fdata      (w_data0)
  );

  wb_bank_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank1 (
    .clk          (clk),
    .rst          (rst),
    .i_push0      (w_acc0 && bank_of(bus.wb0_addr_i)),
    .i_addr0      (bus.wb0_addr_i),
    .i_data0      (bus.wb0_data_i),
    .i_push1      (w_acc1 && bank_of(bus.wb1_addr_i)),
    .i_addr1      (bus.wb1_addr_i),
    .i_data1      (bus.wb1_data_i),
    .o_count      (w_count1),
    .o_head_valid (w_headValid1),
    .o_head_addr  (w_headAddr1),
    .o_head_data  (w_headData1),
    .i_fra        (w_fra),
    .o_fhit       (w_hit1),
    .o_fdata      (w_data1)
  );

  assign bus.we0_o = w_headValid0;
  assign bus.wa0_o = w_headAddr0;
  assign bus.wd0_o = w_headData0;
  assign bus.we1_o = w_headValid1;
  assign bus.wa1_o = w_headAddr1;
  assign bus.wd1_o = w_headData1;

  // r0 is never enqueued, but the explicit guard keeps fhit low regardless.
  always_comb begin
    for (int n = 0; n < WB_NUM_FWD; n++) begin
      w_fhit[n]  = 1'b0;
      w_fdata[n] = '0;
      if (w_fra[n] != 5'd0) begin
        if (bank_of(w_fra[n])) begin
          w_fhit[n]  = w_hit1[n];
          w_fdata[n] = w_data1[n];
        end else begin
          w_fhit[n]  = w_hit0[n];
          w_fdata[n] = w_data0[n];
        end
      end
    end
  end

  assign bus.fhit0_o  = w_fhit[0];
  assign bus.fhit1_o  = w_fhit[1];
  assign bus.fhit2_o  = w_fhit[2];
  assign bus.fhit3_o  = w_fhit[3];
  assign bus.fdata0_o = w_fdata[0];
  assign bus.fdata1_o = w_fdata[1];
  assign bus.fdata2_o = w_fdata[2];
  assign bus.fdata3_o = w_fdata[3];

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios followed by
// random traffic checked against queue-based bank and regfile models.
module tb_reg_wb_arbiter;
  import reg_wb_arbiter_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int NRAND = 1500;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter_if #(.WIDTH(WIDTH)) bus ();

  reg_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Queue occupancy can never legally exceed DEPTH.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      assert ((int'(dut.u_bank0.r_count) <= DEPTH) && (int'(dut.u_bank1.r_count) <= DEPTH))
      else begin
        miscompares++;
        $display("[TB] FAIL count_overflow: got %0d/%0d limit %0d",
                 dut.u_bank0.r_count, dut.u_bank1.r_count, DEPTH);
      end
    end
  end

  task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.wb0_valid_i = v0;
    bus.wb0_addr_i  = a0;
    bus.wb0_data_i  = d0;
    bus.wb1_valid_i = v1;
    bus.wb1_addr_i  = a1;
    bus.wb1_data_i  = d1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic setFra(input logic [4:0] f0, input logic [4:0] f1,
                        input logic [4:0] f2, input logic [4:0] f3);
    bus.fra0_i = f0;
    bus.fra1_i = f1;
    bus.fra2_i = f2;
    bus.fra3_i = f3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic fhitOf(input int n);
    case (n)
      0:       return bus.fhit0_o;
      1:       return bus.fhit1_o;
      2:       return bus.fhit2_o;
      default: return bus.fhit3_o;
    endcase
  endfunction

  function automatic logic [31:0] fdataOf(input int n);
    case (n)
      0:       return bus.fdata0_o;
      1:       return bus.fdata1_o;
      2:       return bus.fdata2_o;
      default: return bus.fdata3_o;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    setFra(5'd4, 5'd5, 5'd6, 5'd7);
    applyStimulus(1'b1, 5'd4, 32'h1, 1'b1, 5'd5, 32'h2);
    repeat (3) tick();
    vectors++;
    if (bus.wb_ready_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: got %b expected 0", bus.wb_ready_o);
    end
    vectors++;
    if ({bus.we0_o, bus.we1_o} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_we: got %b%b expected 00", bus.we0_o, bus.we1_o);
    end
    for (int n = 0; n < 4; n++) begin
      vectors++;
      if (fhitOf(n) !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_fhit%0d: got %b expected 0", n, fhitOf(n));
      end
    end
    idle();
    rst = 1'b0;
    tick();
    vectors++;
    if ({bus.we0_o, bus.we1_o} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL post_reset_we: got %b%b expected 00", bus.we0_o, bus.we1_o);
    end
  endtask

  task automatic test_pair();
    applyStimulus(1'b1, 5'd4, 32'h11, 1'b1, 5'd5, 32'h22);
    #1;
    vectors++;
    if (bus.wb_ready_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pair_ready: got %b expected 1", bus.wb_ready_o);
    end
    tick();
    idle();
    vectors++;
    if ({bus.we0_o, bus.wa0_o, bus.wd0_o} !== {1'b1, 5'd4, 32'h11}) begin
      miscompares++;
      $display("[TB] FAIL pair_port0: got %b/%0d/%h expected 1/4/11", bus.we0_o, bus.wa0_o, bus.wd0_o);
    end
    vectors++;
    if ({bus.we1_o, bus.wa1_o, bus.wd1_o} !== {1'b1, 5'd5, 32'h22}) begin
      miscompares++;
      $display("[TB] FAIL pair_port1: got %b/%0d/%h expected 1/5/22", bus.we1_o, bus.wa1_o, bus.wd1_o);
    end
    tick();
    vectors++;
    if ({bus.we0_o, bus.we1_o} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL pair_drain: got %b%b expected 00", bus.we0_o, bus.we1_o);
    end
  endtask

  task automatic test_same_bank();
    applyStimulus(1'b1, 5'd6, 32'hA, 1'b1, 5'd6, 32'hB);
    tick();
    idle();
    setFra(5'd6, 5'd0, 5'd0, 5'd0);
    #1;
    vectors++;
    if ({bus.we0_o, bus.wa0_o, bus.wd0_o, bus.we1_o} !== {1'b1, 5'd6, 32'hA, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL same_first: got %b/%0d/%h we1=%b expected 1/6/a we1=0",
               bus.we0_o, bus.wa0_o, bus.wd0_o, bus.we1_o);
    end
    vectors++;
    if ({bus.fhit0_o, bus.fdata0_o} !== {1'b1, 32'hB}) begin
      miscompares++;
      $display("[TB] FAIL same_fwd: got %b/%h expected 1/b", bus.fhit0_o, bus.fdata0_o);
    end
    tick();
    vectors++;
    if ({bus.we0_o, bus.wa0_o, bus.wd0_o} !== {1'b1, 5'd6, 32'hB}) begin
      miscompares++;
      $display("[TB] FAIL same_second: got %b/%0d/%h expected 1/6/b", bus.we0_o, bus.wa0_o, bus.wd0_o);
    end
    tick();
    vectors++;
    if ({bus.we0_o, bus.fhit0_o, bus.fdata0_o} !== {1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL same_empty: got we0=%b fhit=%b fdata=%h expected 0/0/0",
               bus.we0_o, bus.fhit0_o, bus.fdata0_o);
    end
  endtask

  task automatic test_zero();
    applyStimulus(1'b1, 5'd0, 32'hFF, 1'b1, 5'd2, 32'h3);
    tick();
    idle();
    setFra(5'd0, 5'd2, 5'd0, 5'd0);
    #1;
    vectors++;
    if ({bus.we0_o, bus.wa0_o, bus.wd0_o, bus.we1_o} !== {1'b1, 5'd2, 32'h3, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL zero_write: got %b/%0d/%h we1=%b expected 1/2/3 we1=0",
               bus.we0_o, bus.wa0_o, bus.wd0_o, bus.we1_o);
    end
    vectors++;
    if ({bus.fhit0_o, bus.fdata0_o} !== {1'b0, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL zero_fwd_r0: got %b/%h expected 0/0", bus.fhit0_o, bus.fdata0_o);
    end
    vectors++;
    if ({bus.fhit1_o, bus.fdata1_o} !== {1'b1, 32'h3}) begin
      miscompares++;
      $display("[TB] FAIL zero_fwd_r2: got %b/%h expected 1/3", bus.fhit1_o, bus.fdata1_o);
    end
    tick();
    vectors++;
    if ({bus.we0_o, bus.we1_o} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL zero_drain: got %b%b expected 00", bus.we0_o, bus.we1_o);
    end
  endtask

  task automatic test_fill();
    int  cnt = 0;
    int  pairIdx = 0;
    int  outIdx = 0;
    bit  sawStall = 1'b0;
    bit  acc;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (pairIdx < 4)
        applyStimulus(1'b1, 5'(4 * pairIdx + 2), 32'(2 * pairIdx + 1),
                      1'b1, 5'(4 * pairIdx + 4), 32'(2 * pairIdx + 2));
      else
        idle();
      #1;
      vectors++;
      if (bus.wb_ready_o !== (cnt <= DEPTH - 2)) begin
        miscompares++;
        $display("[TB] FAIL fill_ready: cycle %0d got %b expected %b", cyc, bus.wb_ready_o, (cnt <= DEPTH - 2));
      end
      acc = (pairIdx < 4) && (cnt <= DEPTH - 2);
      if ((pairIdx < 4) && !(cnt <= DEPTH - 2)) sawStall = 1'b1;
      tick();
      cnt = cnt + (acc ? 2 : 0) - ((cnt != 0) ? 1 : 0);
      if (acc) pairIdx++;
      vectors++;
      if (bus.we0_o !== (cnt != 0)) begin
        miscompares++;
        $display("[TB] FAIL fill_we0: cycle %0d got %b expected %b", cyc, bus.we0_o, (cnt != 0));
      end
      vectors++;
      if (bus.we1_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL fill_we1: cycle %0d got %b expected 0", cyc, bus.we1_o);
      end
      if (bus.we0_o === 1'b1) begin
        vectors++;
        if ((outIdx >= 8) || (bus.wa0_o !== 5'(2 * outIdx + 2)) || (bus.wd0_o !== 32'(outIdx + 1))) begin
          miscompares++;
          $display("[TB] FAIL fill_order: write %0d got r%0d=%h expected r%0d=%h",
                   outIdx, bus.wa0_o, bus.wd0_o, 2 * outIdx + 2, outIdx + 1);
        end
        outIdx++;
      end
    end
    vectors++;
    if ((outIdx != 8) || (pairIdx != 4) || !sawStall) begin
      miscompares++;
      $display("[TB] FAIL fill_totals: got writes=%0d pairs=%0d stall=%b expected 8/4/1",
               outIdx, pairIdx, sawStall);
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 5'd2, 32'h1, 1'b1, 5'd4, 32'h2);
    tick();
    applyStimulus(1'b1, 5'd6, 32'h3, 1'b1, 5'd8, 32'h4);
    tick();
    idle();
    setFra(5'd4, 5'd8, 5'd0, 5'd0);
    #1;
    vectors++;
    if ({bus.we0_o, bus.fhit1_o} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL rstmid_pending: got we0=%b fhit1=%b expected 1/1", bus.we0_o, bus.fhit1_o);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.we0_o, bus.we1_o, bus.wb_ready_o, bus.fhit0_o, bus.fhit1_o} !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL rstmid_async: got we=%b%b rdy=%b fhit=%b%b expected all 0",
               bus.we0_o, bus.we1_o, bus.wb_ready_o, bus.fhit0_o, bus.fhit1_o);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      vectors++;
      if ({bus.we0_o, bus.we1_o, bus.fhit1_o} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL rstmid_stale: cycle %0d got we=%b%b fhit1=%b expected 000",
                 cyc, bus.we0_o, bus.we1_o, bus.fhit1_o);
      end
    end
  endtask

  task automatic test_random();
    wb_req_t     q0[$];
    wb_req_t     q1[$];
    wb_req_t     e;
    logic [31:0] rfModel [32];
    logic [31:0] rfDut   [32];
    logic        v0, v1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [4:0]  f [4];
    logic        expReady, expHit;
    logic [31:0] expData;
    for (int r = 0; r < 32; r++) begin
      rfModel[r] = '0;
      rfDut[r]   = '0;
    end
    for (int cyc = 0; cyc < NRAND; cyc++) begin
      v0 = (cyc < NRAND - 10) && ($urandom_range(0, 3) != 0);
      v1 = (cyc < NRAND - 10) && ($urandom_range(0, 3) != 0);
      a0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      d0 = $urandom;
      d1 = $urandom;
      for (int n = 0; n < 4; n++) f[n] = 5'($urandom_range(0, 7));
      applyStimulus(v0, a0, d0, v1, a1, d1);
      setFra(f[0], f[1], f[2], f[3]);
      #1;
      expReady = (q0.size() <= DEPTH - 2) && (q1.size() <= DEPTH - 2);
      vectors++;
      if (bus.wb_ready_o !== expReady) begin
        miscompares++;
        $display("[TB] FAIL rand_ready: cycle %0d got %b expected %b", cyc, bus.wb_ready_o, expReady);
      end
      for (int n = 0; n < 4; n++) begin
        expHit  = 1'b0;
        expData = '0;
        if (f[n] != 5'd0) begin
          if (f[n][0]) begin
            for (int i = q1.size() - 1; i >= 0; i--)
              if (q1[i].addr == f[n]) begin expHit = 1'b1; expData = q1[i].data; break; end
          end else begin
            for (int i = q0.size() - 1; i >= 0; i--)
              if (q0[i].addr == f[n]) begin expHit = 1'b1; expData = q0[i].data; break; end
          end
        end
        vectors++;
        if ({fhitOf(n), fdataOf(n)} !== {expHit, expData}) begin
          miscompares++;
          $display("[TB] FAIL rand_fwd%0d: cycle %0d r%0d got %b/%h expected %b/%h",
                   n, cyc, f[n], fhitOf(n), fdataOf(n), expHit, expData);
        end
      end
      tick();
      if (q0.size() != 0) begin rfModel[q0[0].addr] = q0[0].data; void'(q0.pop_front()); end
      if (q1.size() != 0) begin rfModel[q1[0].addr] = q1[0].data; void'(q1.pop_front()); end
      if (expReady) begin
        if (v0 && (a0 != 5'd0)) begin
          e.addr = a0; e.data = d0;
          if (a0[0]) q1.push_back(e); else q0.push_back(e);
        end
        if (v1 && (a1 != 5'd0)) begin
          e.addr = a1; e.data = d1;
          if (a1[0]) q1.push_back(e); else q0.push_back(e);
        end
      end
      vectors++;
      if (q0.size() == 0) begin
        if (bus.we0_o !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL rand_port0: cycle %0d got we0=%b expected 0", cyc, bus.we0_o);
        end
      end else if ({bus.we0_o, bus.wa0_o, bus.wd0_o} !== {1'b1, q0[0].addr, q0[0].data}) begin
        miscompares++;
        $display("[TB] FAIL rand_port0: cycle %0d got %b/%0d/%h expected 1/%0d/%h",
                 cyc, bus.we0_o, bus.wa0_o, bus.wd0_o, q0[0].addr, q0[0].data);
      end
      vectors++;
      if (q1.size() == 0) begin
        if (bus.we1_o !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL rand_port1: cycle %0d got we1=%b expected 0", cyc, bus.we1_o);
        end
      end else if ({bus.we1_o, bus.wa1_o, bus.wd1_o} !== {1'b1, q1[0].addr, q1[0].data}) begin
        miscompares++;
        $display("[TB] FAIL rand_port1: cycle %0d got %b/%0d/%h expected 1/%0d/%h",
                 cyc, bus.we1_o, bus.wa1_o, bus.wd1_o, q1[0].addr, q1[0].data);
      end
      if (bus.we0_o === 1'b1) rfDut[bus.wa0_o] = bus.wd0_o;
      if (bus.we1_o === 1'b1) rfDut[bus.wa1_o] = bus.wd1_o;
    end
    for (int r = 0; r < 32; r++) begin
      vectors++;
      if (rfDut[r] !== rfModel[r]) begin
        miscompares++;
        $display("[TB] FAIL rand_regfile: r%0d got %h expected %h", r, rfDut[r], rfModel[r]);
      end
    end
  endtask

  initial begin
    idle();
    setFra(5'd0, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_pair();
    test_same_bank();
    test_zero();
    test_fill();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, register data width.
REQ-002 Parameter DEPTH, default 4, per-bank pending-queue depth; legal values 2..8.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 wb0_valid_i, wb1_valid_i  in  1 each  writeback requests; channel 0 is older in program order than channel 1.
REQ-006 wb0_addr_i, wb1_addr_i  in  5 each  destination register number.
REQ-007 wb0_data_i, wb1_data_i  in  WIDTH each  writeback data.
REQ-008 wb_ready_o  out  1  both channels accepted this cycle when high; the ready is shared by both channels.
REQ-009 wa0_o, wa1_o  out  5 each  regfile write addresses; port 0 carries even registers only, port 1 carries odd registers only.
REQ-010 we0_o, we1_o  out  1 each  regfile write enables.
REQ-011 wd0_o, wd1_o  out  WIDTH each  regfile write data.
REQ-012 fra0_i..fra3_i  in  5 each  read addresses, identical to those driven to the regfile read ports.
REQ-013 fhit0_o..fhit3_o  out  1 each  a pending write to the matching fraN_i exists.
REQ-014 fdata0_o..fdata3_o  out  WIDTH each  data of the youngest pending write to the matching fraN_i.

Function
REQ-015 A request is accepted when wbN_valid_i and wb_ready_o are both high at the clock edge.
REQ-016 An accepted request with addr 0 is discarded and never enqueued.
REQ-017 An accepted request is enqueued into bank addr[0]; bank 0 holds even registers and bank 1 holds odd registers.
REQ-018 When both channels target the same bank in one cycle, channel 0 is enqueued ahead of channel 1.
REQ-019 wb_ready_o = (count_b0 <= DEPTH-2) && (count_b1 <= DEPTH-2), based on registered counts only; a same-cycle dequeue does not raise it.
REQ-020 Each bank head drives its write port directly from flops: we0_o = (count_b0 != 0), wa0_o and wd0_o from the bank-0 head; port 1 is the same for bank 1.
REQ-021 Each non-empty bank dequeues exactly one entry per cycle, unconditionally.
REQ-022 Latency is 1 cycle when the target bank is empty: a request accepted at edge t is on the write port during cycle t+1.
REQ-023 Simultaneous enqueue of 0..2 entries and dequeue of 1 entry in one bank updates the count by the net amount.
REQ-024 Pointers wrap modulo DEPTH.
REQ-025 Count never exceeds DEPTH; an overflow indicates a design bug and is flagged by a bench assertion.
REQ-026 fhitN_o is high if any valid queue entry in bank fraN_i[0] matches fraN_i; entries at the queue head count as pending.
REQ-027 fdataN_o comes from the youngest matching entry, i.e. the one nearest the tail.
REQ-028 fhitN_o is 0 when fraN_i == 0.
REQ-029 fdataN_o is don't-care when fhitN_o is 0 and is driven to 0 in that case.
REQ-030 Forwarding outputs are purely combinational from registered state and fraN_i; same-cycle inputs are not forwarded.
REQ-031 Two writes per cycle reach the regfile only when both banks are non-empty; consequently the regfile's same-bank conflict condition never arises on enabled ports.

Reset
REQ-032 While rst is high: both counts, head and tail pointers = 0; we0_o = we1_o = 0; wb_ready_o = 0; fhit*_o = 0.
REQ-033 Reset asserted mid-operation discards all pending entries immediately (asynchronously).
REQ-034 The first acceptance is possible on the first rising edge after rst deasserts.
REQ-035 Queue data storage needs no reset.

Structure
REQ-036 Shared package holds typedef wb_req_t {addr[4:0], data[WIDTH-1:0]} and constant WB_FIFO_DEPTH_DEFAULT = 4.
REQ-037 One sub-module, wb_bank_fifo, implements a 2-in/1-out per-bank queue with youngest-match lookup on 4 addresses; it is instantiated twice (bank 0, bank 1).

Verification
REQ-038 Scenario: reset release, then wb0 = (r4, 0x11) and wb1 = (r5, 0x22) at edge t -> at t+1, we0=1 wa0=4 wd0=0x11 and we1=1 wa1=5 wd1=0x22; at t+2, both enables are 0.
REQ-039 Scenario: same-bank pair wb0 = (r6, 0xA) and wb1 = (r6, 0xB) -> r6=0xA at t+1 and r6=0xB at t+2; fra0=6 at t+1 gives fhit=1 and fdata=0xB.
REQ-040 Scenario: wb0 = (r0, 0xFF) and wb1 = (r2, 0x3) -> only port 0 writes r2=0x3; no write to r0 ever occurs; fra=0 gives fhit=0.
REQ-041 Scenario: four consecutive accepted even-only pairs -> wb_ready_o falls when count_b0 > 2; writes drain in order one per cycle; no entry is lost.
REQ-042 Scenario: rst pulsed while 3 entries are pending -> enables drop immediately; after release, no stale write appears.
REQ-043 Scenario: random traffic against a reference model of the register file -> final regfile contents match, and every read of a pending register through the forwarding outputs returns the latest value.
